psg: RTL and testbench
======================

PSG -- requirements
Module: psg

Interface
REQ-001 clock  input  1  system clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ce  input  1  chip-rate enable, nominally 1.75 MHz; one-clock pulse per chip cycle.
REQ-004 bdir  input  1  bus direction, AY-3-8910 encoding.
REQ-005 bc1  input  1  bus control, AY-3-8910 encoding.
REQ-006 di  input  8  CPU write data.
REQ-007 do  output  8  CPU read data; combinational from the selected register.
REQ-008 a  output  8  channel A level, unsigned; feeds mixer a1/a2.
REQ-009 b  output  8  channel B level, unsigned.
REQ-010 c  output  8  channel C level, unsigned.

Function
REQ-011 Bus decode SHALL evaluate every clock, independent of ce:
- {bdir,bc1}=11: latch di[3:0] as address, only if di[7:4]=0.
- 10: write di to the latched register.
- 01: read.
- 00: idle.
REQ-012 A latched address SHALL persist until the next valid latch; writes after an invalid latch SHALL still go to the last valid address.
REQ-013 Register width masks SHALL apply on write and show on read:
- R1, R3, R5, R13: 4 bits.
- R6, R8, R9, R10: 5 bits.
- All others: 8 bits.
- Unused bits SHALL read as 0.
REQ-014 Read data SHALL be the masked content of the latched register.
REQ-015 A prescaler SHALL count ce pulses modulo 8 and emit a tick on each wrap, so tick = ce/8.
REQ-016 Each tone channel SHALL have a 12-bit counter.
- On tick: counter+1 >= period, with period 0 treated as 1, clears the counter and toggles the square output.
- Otherwise the counter increments.
REQ-017 Noise SHALL advance on every second tick using a 5-bit counter with the same compare rule on R6 (0 treated as 1).
- Each period, a 17-bit LFSR shifts with feedback bit0 XOR bit3.
- The LFSR SHALL have a nonzero reset seed of 1.
- Noise out is LFSR bit0.
REQ-018 Channel gate SHALL be (tone_out | R7 tone-disable bit) & (noise_out | R7 noise-disable bit).
- Tone-disable bits are R7[0..2] for A..C; noise-disable bits are R7[3..5].
REQ-019 Channel amplitude SHALL be the 4-bit envelope level when volume register bit4=1, otherwise volume[3:0].
REQ-020 Channel output SHALL be VOL_TABLE[amplitude] when the gate is 1, else 0.
- Outputs SHALL be registered, giving one clock latency from the gate/amplitude change.
REQ-021 Envelope step SHALL occur on tick when the 16-bit envelope counter reaches period {R12,R11}, with 0 treated as 1.
REQ-022 Envelope state SHALL comprise a 4-bit level, a direction, and a hold flag. R13 bits are CONT(3), ATT(2), ALT(1), HOLD(0).
REQ-023 Envelope start: on any R13 write, in the same clock the write occurs:
- level = ATT ? 0 : 15;
- direction = ATT;
- hold cleared;
- counter cleared.
REQ-024 Envelope per step, when not held: level moves by 1 in the current direction. At the end of a 16-step cycle:
- CONT=0: hold, level=0.
- CONT=1, HOLD=1: hold at final level, inverted when ALT=1.
- CONT=1, HOLD=0, ALT=1: direction reverses.
- CONT=1, HOLD=0, ALT=0: level wraps, 15->0 or 0->15.
REQ-025 Simultaneous R13 write and envelope step SHALL apply the restart only.
REQ-026 Register writes SHALL take effect on tone/noise/envelope comparisons from the next clock. Counters SHALL NOT be cleared on period writes, except the envelope counter on an R13 write.
REQ-027 A period lowered below the current count SHALL clear the counter and toggle on the next tick.

Reset
REQ-028 Reset SHALL clear all 16 registers, the address latch, the prescaler, all counters, and the tone outputs.
REQ-029 Reset SHALL set the LFSR to 1, the envelope level to 0, and hold to 1.
REQ-030 Reset SHALL drive a=b=c=0 from the first clock after reset asserts.
REQ-031 Reset mid-operation SHALL override ce and bus activity in the same clock.

Structure
REQ-032 Package psg_pkg SHALL hold:
- VOL_TABLE: 16 x 8-bit logarithmic table, 0x00 at entry 0, 0xFF at entry 15.
- Register index constants R_* .
- Bus code constants.
- The per-register width masks.
REQ-033 The envelope generator SHALL be a sub-module psg_env (inputs: tick, shape, period, restart; output: 4-bit level).
REQ-034 Two psg instances SHALL be usable side by side for dual-chip operation without shared state.

Verification
REQ-035 Latch 0x00, write 0xFF, latch 0x01, write 0xFF -> read R0=0xFF, R1=0x0F.
REQ-036 R0=2, R7=0x3E, R8=0x0F, ce every clock -> a toggles between 0xFF and 0 every 16 clocks, b=c=0.
REQ-037 R8=0x10, R11=1, R12=0, R13=0x0D, R7=0x3F -> a ramps through VOL_TABLE[0..15], one step per 8 ce, then holds 0xFF.
REQ-038 R13=0x0E -> triangle: 0..15, 15..0, repeating, with no repeated endpoint step.
REQ-039 Latch 0x10, then write 0x55 -> the last valid register is written and no other register changes.
REQ-040 Assert reset during an active envelope and tone -> next clock a=b=c=0, all reads return 0, and the LFSR restarts from seed 1.

Source files
------------

// File: rtl/psg_pkg.sv
// psg_pkg: shared constants for the PSG.
//   bus_code_e   - {bdir,bc1} bus cycle codes (AY-3-8910 encoding)
//   R_*          - register index constants
//   VOL_TABLE    - 16-entry logarithmic amplitude-to-level table
//   reg_mask()   - implemented-bit mask for each register
package psg_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10,
    BUS_LATCH = 2'b11
  } bus_code_e;

  localparam logic [3:0] R_A_FINE     = 4'd0;
  localparam logic [3:0] R_A_COARSE   = 4'd1;
  localparam logic [3:0] R_B_FINE     = 4'd2;
  localparam logic [3:0] R_B_COARSE   = 4'd3;
  localparam logic [3:0] R_C_FINE     = 4'd4;
  localparam logic [3:0] R_C_COARSE   = 4'd5;
  localparam logic [3:0] R_NOISE      = 4'd6;
  localparam logic [3:0] R_MIXER      = 4'd7;
  localparam logic [3:0] R_A_VOL      = 4'd8;
  localparam logic [3:0] R_B_VOL      = 4'd9;
  localparam logic [3:0] R_C_VOL      = 4'd10;
  localparam logic [3:0] R_ENV_FINE   = 4'd11;
  localparam logic [3:0] R_ENV_COARSE = 4'd12;
  localparam logic [3:0] R_ENV_SHAPE  = 4'd13;
  localparam logic [3:0] R_IO_A       = 4'd14;
  localparam logic [3:0] R_IO_B       = 4'd15;

  localparam logic [7:0] VOL_TABLE [16] = '{
    8'h00, 8'h03, 8'h04, 8'h06, 8'h0A, 8'h0F, 8'h15, 8'h22,
    8'h28, 8'h41, 8'h5B, 8'h72, 8'h90, 8'hB5, 8'hD7, 8'hFF
  };

  localparam logic [7:0] MASK_4 = 8'h0F;
  localparam logic [7:0] MASK_5 = 8'h1F;
  localparam logic [7:0] MASK_8 = 8'hFF;

  function automatic logic [7:0] reg_mask(input logic [3:0] idx);
    case (idx)
      R_A_COARSE, R_B_COARSE, R_C_COARSE, R_ENV_SHAPE: return MASK_4;
      R_NOISE, R_A_VOL, R_B_VOL, R_C_VOL:              return MASK_5;
      default:                                         return MASK_8;
    endcase
  endfunction

endpackage

// File: rtl/psg_if.sv
// psg_if: CPU bus of the PSG.
//   bdir, bc1 - bus control (AY-3-8910 encoding)
//   di        - write data / address byte
//   dout      - read data from the latched register
interface psg_if;
  logic       bdir;
  logic       bc1;
  logic [7:0] di;
  logic [7:0] dout;

  modport master (output bdir, bc1, di, input dout);
  modport slave  (input bdir, bc1, di, output dout);
endinterface

// File: rtl/psg_env.sv
// psg_env: envelope generator.
//   clock, reset - system clock, synchronous active-high reset
//   tick         - prescaled chip-rate tick
//   restart      - restart the envelope this clock (R13 write)
//   shape        - {CONT, ATT, ALT, HOLD}; at restart this is the value being written
//   period       - {R12,R11}, 0 treated as 1
//   level        - current 4-bit envelope level
module psg_env (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        restart,
  input  logic [3:0]  shape,
  input  logic [15:0] period,
  output logic [3:0]  level
);

  logic [15:0] cnt_reg;
  logic [3:0]  level_reg;
  logic        dir_reg;
  logic        hold_reg;

  logic [15:0] period_eff;
  logic [16:0] cnt_inc;
  logic        step;
  logic        cycle_end;

  assign period_eff = (period == 16'd0) ? 16'd1 : period;
  assign cnt_inc    = {1'b0, cnt_reg} + 17'd1;
  assign step       = tick && (cnt_inc >= {1'b0, period_eff});
  // A cycle ends when the level is already at the end it is heading for.
  assign cycle_end  = dir_reg ? (level_reg == 4'hF) : (level_reg == 4'h0);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg   <= '0;
      level_reg <= '0;
      dir_reg   <= 1'b0;
      hold_reg  <= 1'b1;
    end else if (restart) begin
      // Restart wins over a coincident step.
      cnt_reg   <= '0;
      level_reg <= shape[2] ? 4'h0 : 4'hF;
      dir_reg   <= shape[2];
      hold_reg  <= 1'b0;
    end else begin
      if (tick)
        cnt_reg <= step ? 16'd0 : cnt_inc[15:0];
      if (step && !hold_reg) begin
        if (!cycle_end) begin
          level_reg <= dir_reg ? level_reg + 4'd1 : level_reg - 4'd1;
        end else if (!shape[3]) begin
          hold_reg  <= 1'b1;
          level_reg <= 4'h0;
        end else if (shape[0]) begin
          hold_reg  <= 1'b1;
          level_reg <= shape[1] ? ~level_reg : level_reg;
        end else if (shape[1]) begin
          // Reverse and move immediately so the endpoint is not repeated.
          dir_reg   <= ~dir_reg;
          level_reg <= dir_reg ? level_reg - 4'd1 : level_reg + 4'd1;
        end else begin
          level_reg <= ~level_reg;
        end
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/psg.sv
// psg: AY-3-8910 style programmable sound generator.
//   clock, reset - system clock, synchronous active-high reset
//   ce           - chip-rate enable, one-clock pulse per chip cycle
//   bus          - CPU bus (slave side): bdir, bc1, di in; dout out
//   a, b, c      - registered channel levels
module psg
  import psg_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  psg_if.slave       bus,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c
);

  logic [7:0] regs_reg [16];
  logic [3:0] addr_reg;
  bus_code_e  code;
  logic       wr_en;

  assign code  = bus_code_e'({bus.bdir, bus.bc1});
  assign wr_en = (code == BUS_WRITE);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs_reg[i] <= '0;
      addr_reg <= '0;
    end else begin
      // Latch bytes with a nonzero upper nibble are ignored entirely.
      if (code == BUS_LATCH && bus.di[7:4] == 4'h0)
        addr_reg <= bus.di[3:0];
      if (wr_en)
        regs_reg[addr_reg] <= bus.di & reg_mask(addr_reg);
    end
  end

  // Unused bits are masked on write, so the stored value reads back directly.
  assign bus.dout = regs_reg[addr_reg];

  // Prescaler: tick = ce / 8.
  logic [2:0] presc_reg;
  logic       tick;

  assign tick = ce && (presc_reg == 3'd7);

  always_ff @(posedge clock) begin
    if (reset)   presc_reg <= '0;
    else if (ce) presc_reg <= presc_reg + 3'd1;
  end

  // Noise: counter advances on every second tick, LFSR shifts each period.
  logic        noise_div_reg;
  logic [4:0]  ncnt_reg;
  logic [16:0] lfsr_reg;
  logic [4:0]  nper_eff;
  logic [5:0]  ncnt_inc;

  assign nper_eff = (regs_reg[R_NOISE][4:0] == 5'd0) ? 5'd1 : regs_reg[R_NOISE][4:0];
  assign ncnt_inc = {1'b0, ncnt_reg} + 6'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      noise_div_reg <= 1'b0;
      ncnt_reg      <= '0;
      lfsr_reg      <= 17'd1;
    end else if (tick) begin
      noise_div_reg <= ~noise_div_reg;
      if (noise_div_reg) begin
        if (ncnt_inc >= {1'b0, nper_eff}) begin
          ncnt_reg <= '0;
          lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[3], lfsr_reg[16:1]};
        end else begin
          ncnt_reg <= ncnt_inc[4:0];
        end
      end
    end
  end

  // Envelope
  logic       env_restart;
  logic [3:0] env_shape;
  logic [3:0] env_level;

  assign env_restart = wr_en && (addr_reg == R_ENV_SHAPE);
  assign env_shape   = env_restart ? bus.di[3:0] : regs_reg[R_ENV_SHAPE][3:0];

  psg_env u_env (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .restart (env_restart),
    .shape   (env_shape),
    .period  ({regs_reg[R_ENV_COARSE], regs_reg[R_ENV_FINE]}),
    .level   (env_level)
  );

  // Tone channels and output stage
  logic [5:0] mixer;
  logic [7:0] chan_out [3];

  assign mixer = regs_reg[R_MIXER][5:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [11:0] cnt_reg;
      logic        tone_reg;
      logic [7:0]  out_reg;
      logic [11:0] period_eff;
      logic [12:0] cnt_inc;
      logic [4:0]  vol;
      logic [3:0]  amp;
      logic        gate;

      assign period_eff = ({regs_reg[2*gi+1][3:0], regs_reg[2*gi]} == 12'd0) ? 12'd1
                        : {regs_reg[2*gi+1][3:0], regs_reg[2*gi]};
      assign cnt_inc    = {1'b0, cnt_reg} + 13'd1;
      assign vol        = regs_reg[8+gi][4:0];
      assign amp        = vol[4] ? env_level : vol[3:0];
      assign gate       = (tone_reg | mixer[gi]) & (lfsr_reg[0] | mixer[3+gi]);

      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_reg  <= '0;
          tone_reg <= 1'b0;
          out_reg  <= '0;
        end else begin
          if (tick) begin
            // >= so that a period lowered below the count wraps on the next tick.
            if (cnt_inc >= {1'b0, period_eff}) begin
              cnt_reg  <= '0;
              tone_reg <= ~tone_reg;
            end else begin
              cnt_reg  <= cnt_inc[11:0];
            end
          end
          out_reg <= gate ? VOL_TABLE[amp] : 8'h00;
        end
      end

      assign chan_out[gi] = out_reg;
    end
  endgenerate

  assign a = chan_out[0];
  assign b = chan_out[1];
  assign c = chan_out[2];

endmodule

// File: tb/tb_psg.sv
module tb_psg;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce    = 1'b0;
  logic [7:0] a, b, c;

  int vectors     = 0;
  int miscompares = 0;

  psg_if bus_if ();

  psg dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .bus   (bus_if),
    .a     (a),
    .b     (b),
    .c     (c)
  );

  always #5 clock = ~clock;

  logic [7:0] vol_exp  [16] = '{8'h00, 8'h03, 8'h04, 8'h06, 8'h0A, 8'h0F, 8'h15, 8'h22,
                                8'h28, 8'h41, 8'h5B, 8'h72, 8'h90, 8'hB5, 8'hD7, 8'hFF};
  logic [7:0] mask_exp [16] = '{8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'h1F, 8'hFF,
                                8'h1F, 8'h1F, 8'h1F, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF};

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_idle();
    bus_if.bdir = 1'b0;
    bus_if.bc1  = 1'b0;
  endtask

  task automatic bus_latch(input logic [7:0] v);
    bus_if.bdir = 1'b1; bus_if.bc1 = 1'b1; bus_if.di = v;
    @(negedge clock);
    bus_idle();
  endtask

  task automatic bus_write(input logic [7:0] v);
    bus_if.bdir = 1'b1; bus_if.bc1 = 1'b0; bus_if.di = v;
    @(negedge clock);
    bus_idle();
  endtask

  task automatic set_reg(input logic [3:0] r, input logic [7:0] v);
    bus_latch({4'h0, r});
    bus_write(v);
    $display("wr R%0d <= %h", r, v);
  endtask

  task automatic read_reg(input logic [3:0] r, output logic [7:0] v);
    bus_latch({4'h0, r});
    bus_if.bdir = 1'b0; bus_if.bc1 = 1'b1;
    #1 v = bus_if.dout;
    bus_idle();
    $display("rd R%0d = %h", r, v);
  endtask

  // Reset for one clock; whatever ce/bus activity the caller set stays applied.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    check_val("rst_a", {8'h00, a}, 16'h0000);
    check_val("rst_b", {8'h00, b}, 16'h0000);
    check_val("rst_c", {8'h00, c}, 16'h0000);
    reset = 1'b0;
    ce    = 1'b0;
    bus_idle();
    $display("reset");
  endtask

  function automatic int exp_level(input logic [3:0] shape, input int n);
    int m;
    case (shape)
      4'hD: return (n > 15) ? 15 : n;
      4'hE: begin
        m = n % 30;
        return (m <= 15) ? m : 30 - m;
      end
      default: return (n > 15) ? 0 : 15 - n;
    endcase
  endfunction

  // Envelope on channel A, step every tick (8 ce), ce held high.
  task automatic env_test(input logic [3:0] shape, input int nsteps);
    do_reset();
    set_reg(4'd8, 8'h10);
    set_reg(4'd11, 8'h01);
    set_reg(4'd12, 8'h00);
    set_reg(4'd7, 8'h3F);
    set_reg(4'd13, {4'h0, shape});
    ce = 1'b1;
    for (int k = 1; k <= 8 * nsteps; k++) begin
      @(negedge clock);
      check_val("env_a", {8'h00, a}, {8'h00, vol_exp[exp_level(shape, (k - 1) / 8)]});
    end
    check_val("env_b", {8'h00, b}, 16'h0000);
  endtask

  task automatic noise_run(input int ncyc);
    set_reg(4'd6, 8'h00);
    set_reg(4'd7, 8'h37);
    set_reg(4'd8, 8'h0F);
    ce = 1'b1;
    // Seed 1 gives a high first bit; first shift lands 16 clocks in.
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      check_val("noise_a", {8'h00, a}, (k <= 16) ? 16'h00FF : 16'h0000);
    end
  endtask

  logic [7:0] rd;

  initial begin
    bus_if.bdir = 1'b0;
    bus_if.bc1  = 1'b0;
    bus_if.di   = 8'h00;
    @(negedge clock);
    do_reset();
    check_val("rst_dout", {8'h00, bus_if.dout}, 16'h0000);

    // Write masks on every register
    set_reg(4'd0, 8'hFF);
    set_reg(4'd1, 8'hFF);
    read_reg(4'd0, rd); check_val("r0_ff", {8'h00, rd}, 16'h00FF);
    read_reg(4'd1, rd); check_val("r1_mask", {8'h00, rd}, 16'h000F);
    for (int r = 2; r < 16; r++) set_reg(r[3:0], 8'hFF);
    for (int r = 0; r < 16; r++) begin
      read_reg(r[3:0], rd);
      check_val("mask", {8'h00, rd}, {8'h00, mask_exp[r]});
    end

    // Invalid latch keeps the last valid address
    do_reset();
    set_reg(4'd2, 8'h11);
    bus_latch(8'h10);
    #1 check_val("inv_latch_keep", {8'h00, bus_if.dout}, 16'h0011);
    bus_write(8'h55);
    for (int r = 0; r < 16; r++) begin
      read_reg(r[3:0], rd);
      check_val("inv_latch_regs", {8'h00, rd}, (r == 2) ? 16'h0055 : 16'h0000);
    end

    // Tone A, period 2, ce every clock: toggles every 16 clocks
    do_reset();
    set_reg(4'd0, 8'h02);
    set_reg(4'd7, 8'h3E);
    set_reg(4'd8, 8'h0F);
    ce = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock);
      check_val("tone_a", {8'h00, a}, (((k - 1) >> 4) & 1) != 0 ? 16'h00FF : 16'h0000);
      if (k % 16 == 0) begin
        check_val("tone_b", {8'h00, b}, 16'h0000);
        check_val("tone_c", {8'h00, c}, 16'h0000);
      end
    end

    // Envelope shapes: attack+hold, triangle, decay+hold at 0
    env_test(4'hD, 20);
    env_test(4'hE, 66);
    env_test(4'h0, 20);

    // Noise, then reset mid-run with ce and a bus write active
    do_reset();
    noise_run(40);
    ce = 1'b1;
    bus_if.bdir = 1'b1; bus_if.bc1 = 1'b0; bus_if.di = 8'hAA;
    do_reset();
    for (int r = 0; r < 16; r++) begin
      read_reg(r[3:0], rd);
      check_val("midrst_regs", {8'h00, rd}, 16'h0000);
    end
    noise_run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
